seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit seven-segment display. It latches a packed multi-digit hex value and cycles through the digits at a fixed prescaled rate. Each slot presents one 4-bit nibble plus a one-hot digit enable, with dead time and leading-zero blanking. It sits directly upstream of `seven_segment`: `digit` drives that decoder's `in`, and `digit_sel` drives the display common lines.

---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_scan_ctrl_prescaler.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 93 +++++++++
 tb/tb_seg_scan_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_scan_ctrl_pkg;
  localparam int   DEF_NUM_DIGITS = 4;
  localparam int   DEF_SCAN_DIV   = 50000;
  localparam int   DEF_DEAD_CYC   = 2;
  localparam int   SEG_NIB_W      = 4;
  localparam logic SEG_SEL_OFF    = 1'b0;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_e;
endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Modulo-N counter with clear, count enable and terminal-count flag.
module scan_prescaler #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         tc_o
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o      = en_i && (cnt_q == LAST);
  assign cnt_nxt_o = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) cnt_d = '0;
    else if (en_i)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: shadow register, slot
// sequencing with dead time, leading-zero blanking and registered outputs.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int DEAD_CYC   = DEF_DEAD_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            load,
  input  logic [SEG_NIB_W*NUM_DIGITS-1:0] value,
  input  logic                            blank_lz,
  output logic [SEG_NIB_W-1:0]            digit,
  output logic [NUM_DIGITS-1:0]           digit_sel,
  output logic                            frame_start
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] DEAD_END = PRE_W'(DEAD_CYC);

  logic [NUM_DIGITS-1:0][SEG_NIB_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRE_W-1:0]      pre_d;
  logic                  tc, run_q, upper_zero;
  logic [NUM_DIGITS-1:0] blank_mask;
  phase_e                phase_d;
  logic [SEG_NIB_W-1:0]  digit_q, digit_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fs_q, fs_d;

  // run_q holds the counter at 0 on the first enabled edge so slot 0
  // always starts with a full DEAD phase and a frame_start pulse.
  scan_prescaler #(.N(SCAN_DIV)) u_pre (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!enable),
    .en_i      (enable && run_q),
    .cnt_nxt_o (pre_d),
    .tc_o      (tc)
  );

  always_comb begin
    shadow_d = load ? value : shadow_q;
    idx_d    = idx_q;
    if (!enable)   idx_d = '0;
    else if (tc)   idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Digit k blanks when it and every more significant nibble are zero.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero    = upper_zero && (shadow_q[k] == '0);
      blank_mask[k] = upper_zero;
    end
  end

  always_comb begin
    phase_d = (pre_d < DEAD_END) ? PH_DEAD : PH_ON;
    digit_d = shadow_q[idx_d];
    sel_d   = {NUM_DIGITS{SEG_SEL_OFF}};
    if (enable && phase_d == PH_ON && !(blank_lz && blank_mask[idx_d]))
      sel_d = NUM_DIGITS'(1) << idx_d;
    fs_d    = enable && (!run_q || (tc && idx_q == IDX_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      digit_q  <= '0;
      sel_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      run_q    <= enable;
      digit_q  <= digit_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
    end
  end

  assign digit       = digit_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed vector bench for seg_scan_ctrl (4 digits, 4-cycle slots, 1 dead cycle).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  digit;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .digit       (digit),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        blz;
    logic [3:0]  dig;
    logic [3:0]  sel;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  function automatic void r(logic ld, logic [15:0] val, logic blz,
                            logic [3:0] dig, logic [3:0] sel, logic fs);
    vec_t v;
    v.ld = ld; v.val = val; v.blz = blz; v.dig = dig; v.sel = sel; v.fs = fs;
    tbl.push_back(v);
  endfunction

  // One full slot without load: dead row (digit d0, frame flag fs), then 3 ON rows.
  function automatic void s(logic blz, logic [3:0] d0, logic [3:0] d,
                            logic [3:0] sel, logic fs);
    r(1'b0, 16'hDEAD, blz, d0, 4'h0, fs);
    for (int i = 0; i < 3; i++) r(1'b0, 16'hDEAD, blz, d, sel, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] dig,
                         input logic [3:0] sel, input logic fs);
    chk({tag, ".digit"},       32'(digit),       32'(dig));
    chk({tag, ".digit_sel"},   32'(digit_sel),   32'(sel));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
  endtask

  initial begin
    // Reset scan, no data: 0,1,1,1 / 0,2,2,2 / 0,4,4,4 / 0,8,8,8
    s(0, 4'h0, 4'h0, 4'h1, 1); s(0, 4'h0, 4'h0, 4'h2, 0);
    s(0, 4'h0, 4'h0, 4'h4, 0); s(0, 4'h0, 4'h0, 4'h8, 0);
    // Load 1A3F in slot 0; new nibble appears one edge after capture
    r(0, 16'hDEAD, 0, 4'h0, 4'h0, 1);
    r(1, 16'h1A3F, 0, 4'h0, 4'h1, 0);
    r(0, 16'hDEAD, 0, 4'hF, 4'h1, 0); r(0, 16'hDEAD, 0, 4'hF, 4'h1, 0);
    s(0, 4'h3, 4'h3, 4'h2, 0); s(0, 4'hA, 4'hA, 4'h4, 0); s(0, 4'h1, 4'h1, 4'h8, 0);
    // Blanking with 0005: only slot 0 lit
    r(0, 16'hDEAD, 0, 4'hF, 4'h0, 1);
    r(1, 16'h0005, 1, 4'hF, 4'h1, 0);
    r(0, 16'hDEAD, 1, 4'h5, 4'h1, 0); r(0, 16'hDEAD, 1, 4'h5, 4'h1, 0);
    s(1, 4'h0, 4'h0, 4'h0, 0); s(1, 4'h0, 4'h0, 4'h0, 0); s(1, 4'h0, 4'h0, 4'h0, 0);
    // Value 0000: digit 0 still shows "0"
    r(0, 16'hDEAD, 1, 4'h5, 4'h0, 1);
    r(1, 16'h0000, 1, 4'h5, 4'h1, 0);
    r(0, 16'hDEAD, 1, 4'h0, 4'h1, 0); r(0, 16'hDEAD, 1, 4'h0, 4'h1, 0);
    s(1, 4'h0, 4'h0, 4'h0, 0); s(1, 4'h0, 4'h0, 4'h0, 0); s(1, 4'h0, 4'h0, 4'h0, 0);
    // 0300: internal zero kept, only slot 3 blanked
    r(0, 16'hDEAD, 1, 4'h0, 4'h0, 1);
    r(1, 16'h0300, 1, 4'h0, 4'h1, 0);
    r(0, 16'hDEAD, 1, 4'h0, 4'h1, 0); r(0, 16'hDEAD, 1, 4'h0, 4'h1, 0);
    s(1, 4'h0, 4'h0, 4'h2, 0); s(1, 4'h3, 4'h3, 4'h4, 0); s(1, 4'h0, 4'h0, 4'h0, 0);
    r(0, 16'hDEAD, 1, 4'h0, 4'h0, 1);

    rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; value = 16'h0;
    #12;
    chk_out("reset", 4'h0, 4'h0, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      load = tbl[i].ld; value = tbl[i].val; blank_lz = tbl[i].blz;
      step();
      chk_out($sformatf("row%0d", i), tbl[i].dig, tbl[i].sel, tbl[i].fs);
    end

    // Enable dropped mid slot 2, then re-enabled
    load = 1'b0; blank_lz = 1'b0;
    repeat (8) step();
    step();
    chk_out("slot2_on", 4'h3, 4'h4, 1'b0);
    enable = 1'b0;
    step();
    chk_out("dis_1", 4'h0, 4'h0, 1'b0);
    step();
    chk_out("dis_2", 4'h0, 4'h0, 1'b0);
    enable = 1'b1;
    step();
    chk_out("reen_dead", 4'h0, 4'h0, 1'b1);
    step();
    chk_out("reen_on1", 4'h0, 4'h1, 1'b0);
    repeat (2) step();
    chk_out("reen_on3", 4'h0, 4'h1, 1'b0);
    step();
    chk_out("reen_slot1_dead", 4'h0, 4'h0, 1'b0);

    // Short asynchronous reset pulse mid-slot
    repeat (2) step();
    chk_out("pre_rst", 4'h0, 4'h2, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'h0, 4'h0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk_out("post_rst_start", 4'h0, 4'h0, 1'b1);
    repeat (8) step();
    step();
    chk_out("post_rst_slot2", 4'h0, 4'h4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
